// File: rtl/lcd_hex_sequencer_if.sv
// LCD pin bundle between the sequencer (master) and the GPIO_1 LCD header (slave).
interface lcd_hex_sequencer_if;
    logic       lcd_rs;
    logic       lcd_e;
    logic [7:0] lcd_d;

    modport master (output lcd_rs, output lcd_e, output lcd_d);
    modport slave  (input  lcd_rs, input  lcd_e, input  lcd_d);
endinterface

// File: rtl/lcd_hex_sequencer.sv
// HD44780 16x2 LCD sequencer: power-on init, then shows two 64-bit values as hex.
// Optional feature macro LCD_IDLE_EN: park in IDLE after each frame and only
// redraw when {a,b} differs from the snapshot on screen.
//
// state | meaning
// PWRON | power-on delay before the first command
// SETUP | rs/d driven for the current step, E low (2 cycles)
// EHIGH | E strobe high for T_E cycles
// WAIT  | E low, command execution time (T_CLEAR after clear)
// IDLE  | frame shown, waiting for an input change (LCD_IDLE_EN only)
module lcd_hex_sequencer #(
    parameter int T_PWRON = 750000,
    parameter int T_E     = 16,
    parameter int T_EXEC  = 2000,
    parameter int T_CLEAR = 80000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [63:0]                a,
    input  logic [63:0]                b,
    lcd_hex_sequencer_if.master        lcd,
    output logic                       init_done,
    output logic                       frame_done
);

    localparam logic [31:0] TC_PWRON = 32'(T_PWRON);
    localparam logic [31:0] TC_E     = 32'(T_E - 1);
    localparam logic [31:0] TC_EXEC  = 32'(T_EXEC - 1);
    localparam logic [31:0] TC_CLEAR = 32'(T_CLEAR - 1);

    localparam logic [5:0] STEP_FIRST_FRAME = 6'd6;
    localparam logic [5:0] STEP_LAST_INIT   = 6'd5;
    localparam logic [5:0] STEP_CLEAR       = 6'd4;
    localparam logic [5:0] STEP_LAST       = 6'd39;

    typedef enum logic [2:0] {
        PWRON,
        SETUP,
        EHIGH,
`ifdef LCD_IDLE_EN
        IDLE,
`endif
        WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  step_q, step_d;
    logic [31:0] cnt_q, cnt_d;
    logic        lcd_rs_q, lcd_rs_d;
    logic        lcd_e_q, lcd_e_d;
    logic [7:0]  lcd_d_q, lcd_d_d;
    logic        init_done_q, init_done_d;
    logic        frame_done_q, frame_done_d;
    logic [63:0] shadow_a_q, shadow_a_d;
    logic [63:0] shadow_b_q, shadow_b_d;
    logic        enter_setup;
    logic [31:0] wait_tc;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Digit 0 is the most significant nibble.
    function automatic logic [3:0] nibble_at(input logic [63:0] v, input logic [3:0] k);
        logic [63:0] sh;
        sh = v << {k, 2'b00};
        return sh[63:60];
    endfunction

    // {rs, d} for a given step; digits always come from the shadows.
    function automatic logic [8:0] step_byte(input logic [5:0] step,
                                             input logic [63:0] sa,
                                             input logic [63:0] sb);
        logic [8:0] r;
        r = 9'h000;
        case (step)
            6'd0, 6'd1, 6'd2: r = {1'b0, 8'h38};
            6'd3:             r = {1'b0, 8'h0C};
            6'd4:             r = {1'b0, 8'h01};
            6'd5:             r = {1'b0, 8'h06};
            6'd6:             r = {1'b0, 8'h80};
            6'd23:            r = {1'b0, 8'hC0};
            default: begin
                if (step >= 6'd7 && step <= 6'd22)
                    r = {1'b1, hex_ascii(nibble_at(sa, 4'(step - 6'd7)))};
                else if (step >= 6'd24 && step <= 6'd39)
                    r = {1'b1, hex_ascii(nibble_at(sb, 4'(step - 6'd24)))};
            end
        endcase
        return r;
    endfunction

    assign wait_tc = (step_q == STEP_CLEAR) ? TC_CLEAR : TC_EXEC;

    // Next-state, next-step and registered-output computation.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        cnt_d        = cnt_q + 32'd1;
        lcd_rs_d     = lcd_rs_q;
        lcd_e_d      = lcd_e_q;
        lcd_d_d      = lcd_d_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        shadow_a_d   = shadow_a_q;
        shadow_b_d   = shadow_b_q;
        enter_setup  = 1'b0;

        case (state_q)
            PWRON: begin
                if (cnt_q == TC_PWRON) enter_setup = 1'b1;
            end
            SETUP: begin
                if (cnt_q == 32'd1) begin
                    state_d = EHIGH;
                    cnt_d   = '0;
                    lcd_e_d = 1'b1;
                end
            end
            EHIGH: begin
                if (cnt_q == TC_E) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    lcd_e_d = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_q == wait_tc) begin
                    if (step_q == STEP_LAST_INIT) init_done_d = 1'b1;
                    if (step_q == STEP_LAST) begin
                        frame_done_d = 1'b1;
                        step_d       = STEP_FIRST_FRAME;
`ifdef LCD_IDLE_EN
                        state_d      = IDLE;
                        cnt_d        = '0;
`else
                        enter_setup  = 1'b1;
`endif
                    end else begin
                        step_d      = step_q + 6'd1;
                        enter_setup = 1'b1;
                    end
                end
            end
`ifdef LCD_IDLE_EN
            IDLE: begin
                cnt_d = cnt_q;
                if ({a, b} != {shadow_a_q, shadow_b_q}) enter_setup = 1'b1;
            end
`endif
            default: begin
                state_d = PWRON;
                step_d  = '0;
                cnt_d   = '0;
            end
        endcase

        // Every SETUP entry loads the byte; step 6 entry also re-snapshots a/b.
        if (enter_setup) begin
            state_d              = SETUP;
            cnt_d                = '0;
            {lcd_rs_d, lcd_d_d}  = step_byte(step_d, shadow_a_q, shadow_b_q);
            if (step_d == STEP_FIRST_FRAME) begin
                shadow_a_d = a;
                shadow_b_d = b;
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= PWRON;
            step_q       <= '0;
            cnt_q        <= '0;
            lcd_rs_q     <= 1'b0;
            lcd_e_q      <= 1'b0;
            lcd_d_q      <= 8'h00;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            shadow_a_q   <= '0;
            shadow_b_q   <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_e_q      <= lcd_e_d;
            lcd_d_q      <= lcd_d_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            shadow_a_q   <= shadow_a_d;
            shadow_b_q   <= shadow_b_d;
        end
    end

    assign lcd.lcd_rs  = lcd_rs_q;
    assign lcd.lcd_e   = lcd_e_q;
    assign lcd.lcd_d   = lcd_d_q;
    assign init_done   = init_done_q;
    assign frame_done  = frame_done_q;

endmodule
